// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences one load or store at a time onto a
// request/grant data bus, with lane steering, load extension, misalignment and timeout.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ex_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [1:0]  i_load_size,
  input  logic        i_load_signed,
  input  logic [1:0]  i_store_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd_addr,
  output logic        o_lsu_busy,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic [31:0] o_fault_addr,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // WAIT lasts TIMEOUT-1 cycles, so bus_err lands TIMEOUT cycles after the grant cycle
  localparam int CW = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] FIRE_CNT = CW'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);

  state_t r_state, w_nextState;

  logic          r_isLoad;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [4:0]    r_rd;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_wbData;
  logic          r_misalign;
  logic          r_busErr;
  logic [31:0]   r_faultAddr;

  logic        w_canAccept;
  logic [1:0]  w_size;
  logic        w_aligned;
  logic        w_acceptOk;
  logic        w_acceptBad;
  logic        w_timeout;
  logic        w_inReq;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;

  assign w_canAccept = (r_state == IDLE) || (r_state == RESP);
  assign w_size      = i_mem_read ? i_load_size : i_store_size;

  always_comb begin
    w_aligned = 1'b1;
    case (w_size)
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~i_addr[0];
      default: w_aligned = (i_addr[1:0] == 2'b00);
    endcase
  end

  assign w_acceptOk  = w_canAccept & i_ex_valid & (i_mem_read | i_mem_write) & w_aligned;
  assign w_acceptBad = w_canAccept & i_ex_valid & (i_mem_read | i_mem_write) & ~w_aligned;
  assign w_timeout   = (r_state == WAIT) & ~i_dmem_rvalid & (r_cnt == FIRE_CNT);

  always_comb begin
    w_byte = i_dmem_rdata[7:0];
    case (r_addr[1:0])
      2'b00: w_byte = i_dmem_rdata[7:0];
      2'b01: w_byte = i_dmem_rdata[15:8];
      2'b10: w_byte = i_dmem_rdata[23:16];
      2'b11: w_byte = i_dmem_rdata[31:24];
      default: w_byte = i_dmem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_loadData = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_loadData = {{16{r_signed & w_half[15]}}, w_half};
      default: w_loadData = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_acceptOk) w_nextState = REQ;
      REQ:  if (i_dmem_gnt) w_nextState = r_isLoad ? WAIT : IDLE;
      WAIT: begin
        if (i_dmem_rvalid)  w_nextState = RESP;
        else if (w_timeout) w_nextState = IDLE;
      end
      RESP: w_nextState = w_acceptOk ? REQ : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_isLoad    <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_wbData    <= '0;
      r_misalign  <= 1'b0;
      r_busErr    <= 1'b0;
      r_faultAddr <= '0;
    end else begin
      r_misalign <= w_acceptBad;
      r_busErr   <= w_timeout;
      if (w_acceptBad)    r_faultAddr <= i_addr;
      else if (w_timeout) r_faultAddr <= r_addr;
      if (w_acceptOk) begin
        r_isLoad <= i_mem_read;
        r_size   <= w_size;
        r_signed <= i_load_signed;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
        r_rd     <= i_rd_addr;
      end
      if ((r_state == REQ) && i_dmem_gnt)
        r_cnt <= '0;
      else if ((r_state == WAIT) && !i_dmem_rvalid && (r_cnt != FIRE_CNT))
        r_cnt <= r_cnt + CW'(1);
      if ((r_state == WAIT) && i_dmem_rvalid) r_wbData <= w_loadData;
    end
  end

  // Bus fields come only from latched state and are zero outside REQ
  assign w_inReq = (r_state == REQ);

  always_comb begin
    o_lsu_busy   = w_acceptOk | (r_state == REQ) | (r_state == WAIT);
    o_wb_valid   = (r_state == RESP);
    o_wb_rd      = r_rd;
    o_wb_data    = r_wbData;
    o_misalign   = r_misalign;
    o_bus_err    = r_busErr;
    o_fault_addr = r_faultAddr;
    o_dmem_req   = w_inReq;
    o_dmem_we    = w_inReq & ~r_isLoad;
    o_dmem_addr  = w_inReq ? {r_addr[31:2], 2'b00} : 32'h0;
    o_dmem_be    = 4'b0000;
    o_dmem_wdata = 32'h0;
    if (w_inReq) begin
      if (r_isLoad) begin
        o_dmem_be = 4'b1111;
      end else begin
        case (r_size)
          2'b00: begin
            o_dmem_be    = 4'b0001 << r_addr[1:0];
            o_dmem_wdata = {4{r_wdata[7:0]}};
          end
          2'b01: begin
            o_dmem_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            o_dmem_wdata = {2{r_wdata[15:0]}};
          end
          default: begin
            o_dmem_be    = 4'b1111;
            o_dmem_wdata = r_wdata;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected bus, writeback and
// fault events; a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_ctrl;

  localparam int TO = 4;

  localparam int K_BUS   = 0;
  localparam int K_WB    = 1;
  localparam int K_MIS   = 2;
  localparam int K_BERR  = 3;
  localparam int K_ZERO  = 4;
  localparam int K_QUIET = 5;

  localparam int M_OK      = 0;
  localparam int M_MIS     = 1;
  localparam int M_TMO     = 2;
  localparam int M_ABANDON = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exValid = 1'b0, memRead = 1'b0, memWrite = 1'b0, loadSigned = 1'b0;
  logic [1:0]  loadSize = 2'b00, storeSize = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [4:0]  rdAddr = 5'h0;
  logic        dmemGnt = 1'b0, dmemRvalid = 1'b0;
  logic [31:0] dmemRdata = 32'h0;

  logic        lsuBusy, wbValid, misalign, busErr, dmemReq, dmemWe;
  logic [4:0]  wbRd;
  logic [31:0] wbData, faultAddr, dmemAddr, dmemWdata;
  logic [3:0]  dmemBe;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(exValid), .i_mem_read(memRead),
    .i_mem_write(memWrite), .i_load_size(loadSize), .i_load_signed(loadSigned),
    .i_store_size(storeSize), .i_addr(addr), .i_wdata(wdata), .i_rd_addr(rdAddr),
    .o_lsu_busy(lsuBusy), .o_wb_valid(wbValid), .o_wb_rd(wbRd), .o_wb_data(wbData),
    .o_misalign(misalign), .o_bus_err(busErr), .o_fault_addr(faultAddr),
    .o_dmem_req(dmemReq), .o_dmem_we(dmemWe), .o_dmem_addr(dmemAddr),
    .o_dmem_be(dmemBe), .o_dmem_wdata(dmemWdata), .i_dmem_gnt(dmemGnt),
    .i_dmem_rvalid(dmemRvalid), .i_dmem_rdata(dmemRdata)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    logic [31:0] d;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  bit   expBusy[int];
  int   compared = 0;
  int   mismatched = 0;

  int gntDelay = 0, rvDelay = 0, reqWait = 0, respWait = 0;
  bit waitingResp = 1'b0, strayRvalid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cycle, got, exp);
    end
  endtask

  function automatic int findItem(input int kind);
    foreach (sb[i]) if (sb[i].kind == kind) return i;
    return -1;
  endfunction

  function automatic int findAt(input int kind, input int cyc);
    foreach (sb[i]) if (sb[i].kind == kind && sb[i].cyc == cyc) return i;
    return -1;
  endfunction

  task automatic pushItem(input int kind, input int cyc, input logic [31:0] a, input logic [3:0] be,
                          input logic we, input logic [31:0] d, input logic [4:0] rd);
    exp_t e;
    e.kind = kind; e.cyc = cyc; e.a = a; e.be = be; e.we = we; e.d = d; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  // Bus slave model: grants after gntDelay cycles of req, returns load data rvDelay cycles later
  always @(posedge clk) begin
    #2;
    dmemRvalid = strayRvalid;
    if (waitingResp) begin
      if (respWait == rvDelay) begin
        dmemRvalid  = 1'b1;
        waitingResp = 1'b0;
      end else begin
        respWait++;
      end
    end
    dmemGnt = 1'b0;
    if (dmemReq) begin
      if (reqWait == gntDelay) begin
        dmemGnt = 1'b1;
        reqWait = 0;
        if (!dmemWe) begin
          waitingResp = 1'b1;
          respWait    = 0;
        end
      end else begin
        reqWait++;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard
  always @(negedge clk) begin
    int idx;
    if (expBusy.exists(cycle)) checkOutput("busy", 32'(lsuBusy), 32'(expBusy[cycle]));
    idx = findAt(K_ZERO, cycle);
    if (idx >= 0) begin
      checkOutput("zero_busy", 32'(lsuBusy), 32'h0);
      checkOutput("zero_wb_valid", 32'(wbValid), 32'h0);
      checkOutput("zero_wb_rd", 32'(wbRd), 32'h0);
      checkOutput("zero_wb_data", wbData, 32'h0);
      checkOutput("zero_misalign", 32'(misalign), 32'h0);
      checkOutput("zero_bus_err", 32'(busErr), 32'h0);
      checkOutput("zero_fault_addr", faultAddr, 32'h0);
      checkOutput("zero_dmem_req", 32'(dmemReq), 32'h0);
      checkOutput("zero_dmem_we", 32'(dmemWe), 32'h0);
      checkOutput("zero_dmem_addr", dmemAddr, 32'h0);
      checkOutput("zero_dmem_be", 32'(dmemBe), 32'h0);
      checkOutput("zero_dmem_wdata", dmemWdata, 32'h0);
      sb.delete(idx);
    end
    idx = findAt(K_QUIET, cycle);
    if (idx >= 0) begin
      checkOutput("quiet_wb_valid", 32'(wbValid), 32'h0);
      checkOutput("quiet_bus_err", 32'(busErr), 32'h0);
      checkOutput("quiet_misalign", 32'(misalign), 32'h0);
      checkOutput("quiet_dmem_req", 32'(dmemReq), 32'h0);
      sb.delete(idx);
    end
    if (dmemReq) begin
      idx = findItem(K_BUS);
      if (idx < 0) begin
        checkOutput("unexpected_req", 32'(dmemReq), 32'h0);
      end else begin
        checkOutput("dmem_addr", dmemAddr, sb[idx].a);
        checkOutput("dmem_be", 32'(dmemBe), 32'(sb[idx].be));
        checkOutput("dmem_we", 32'(dmemWe), 32'(sb[idx].we));
        if (sb[idx].we) checkOutput("dmem_wdata", dmemWdata, sb[idx].d);
        if (dmemGnt) begin
          checkOutput("grant_cycle", 32'(cycle), 32'(sb[idx].cyc));
          sb.delete(idx);
        end
      end
    end
    if (wbValid) begin
      idx = findItem(K_WB);
      if (idx < 0) begin
        checkOutput("unexpected_wb_valid", 32'(wbValid), 32'h0);
      end else begin
        checkOutput("wb_cycle", 32'(cycle), 32'(sb[idx].cyc));
        checkOutput("wb_rd", 32'(wbRd), 32'(sb[idx].rd));
        checkOutput("wb_data", wbData, sb[idx].d);
        sb.delete(idx);
      end
    end
    if (misalign) begin
      idx = findItem(K_MIS);
      if (idx < 0) begin
        checkOutput("unexpected_misalign", 32'(misalign), 32'h0);
      end else begin
        checkOutput("misalign_cycle", 32'(cycle), 32'(sb[idx].cyc));
        checkOutput("misalign_fault_addr", faultAddr, sb[idx].a);
        sb.delete(idx);
      end
    end
    if (busErr) begin
      idx = findItem(K_BERR);
      if (idx < 0) begin
        checkOutput("unexpected_bus_err", 32'(busErr), 32'h0);
      end else begin
        checkOutput("bus_err_cycle", 32'(cycle), 32'(sb[idx].cyc));
        checkOutput("bus_err_fault_addr", faultAddr, sb[idx].a);
        sb.delete(idx);
      end
    end
  end

  // Issues one access at posedge+1 and records every event it must produce
  task automatic applyStimulus(input bit rdOp, input bit wrOp, input logic [1:0] lsz,
                               input logic [1:0] ssz, input bit sgn, input logic [31:0] a,
                               input logic [31:0] wd, input logic [4:0] rd, input int gD,
                               input int rD, input logic [31:0] rdat, input int mode,
                               input logic [31:0] expAddr, input logic [3:0] expBe,
                               input logic [31:0] expWd, input logic [31:0] expWb,
                               input bit block);
    int aCyc, g, endC;
    gntDelay = gD; rvDelay = rD; reqWait = 0; respWait = 0; waitingResp = 1'b0;
    dmemRdata = rdat;
    exValid = 1'b1; memRead = rdOp; memWrite = wrOp;
    loadSize = lsz; storeSize = ssz; loadSigned = sgn;
    addr = a; wdata = wd; rdAddr = rd;
    aCyc = cycle;
    g = aCyc + 1 + gD;
    endC = aCyc + 2;
    if (mode == M_MIS) begin
      pushItem(K_MIS, aCyc + 1, a, 4'h0, 1'b0, 32'h0, 5'h0);
      expBusy[aCyc] = 1'b0;
    end else begin
      pushItem(K_BUS, g, expAddr, expBe, ~rdOp, expWd, 5'h0);
      for (int c = aCyc; c <= g; c++) expBusy[c] = 1'b1;
      if (!rdOp) begin
        expBusy[g + 1] = 1'b0;
        endC = g + 1;
      end else if (mode == M_OK) begin
        pushItem(K_WB, g + 2 + rD, 32'h0, 4'h0, 1'b0, expWb, rd);
        for (int c = g + 1; c <= g + 1 + rD; c++) expBusy[c] = 1'b1;
        expBusy[g + 2 + rD] = 1'b0;
        endC = g + 2 + rD;
      end else if (mode == M_TMO) begin
        pushItem(K_BERR, g + TO, a, 4'h0, 1'b0, 32'h0, 5'h0);
        for (int c = g + 1; c <= g + TO - 1; c++) expBusy[c] = 1'b1;
        expBusy[g + TO] = 1'b0;
        endC = g + TO;
      end else begin
        expBusy[g + 1] = 1'b1;
        endC = g + 1;
      end
    end
    @(posedge clk); #1;
    exValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    if (block) while (cycle <= endC) begin @(posedge clk); #1; end
  endtask

  initial begin
    int s;
    repeat (3) begin @(posedge clk); #1; end
    pushItem(K_ZERO, cycle, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] loads with sign/zero extension and grant/rvalid delays");
    applyStimulus(1, 0, 2'b00, 2'b00, 1, 32'h0000_1003, 32'h0, 5'd5, 0, 0, 32'h80FF_1234,
                  M_OK, 32'h0000_1000, 4'hF, 32'h0, 32'hFFFF_FF80, 1);
    applyStimulus(1, 0, 2'b01, 2'b01, 0, 32'h0000_2002, 32'h0, 5'd7, 2, 0, 32'hBEEF_0000,
                  M_OK, 32'h0000_2000, 4'hF, 32'h0, 32'h0000_BEEF, 1);
    applyStimulus(1, 0, 2'b00, 2'b00, 0, 32'h0000_6001, 32'h0, 5'd9, 0, 0, 32'h1234_F0AA,
                  M_OK, 32'h0000_6000, 4'hF, 32'h0, 32'h0000_00F0, 1);
    applyStimulus(1, 0, 2'b01, 2'b01, 1, 32'h0000_6000, 32'h0, 5'd10, 0, 0, 32'h0000_8001,
                  M_OK, 32'h0000_6000, 4'hF, 32'h0, 32'hFFFF_8001, 1);
    applyStimulus(1, 0, 2'b11, 2'b11, 1, 32'h0000_6004, 32'h0, 5'd11, 0, 2, 32'hDEAD_BEEF,
                  M_OK, 32'h0000_6004, 4'hF, 32'h0, 32'hDEAD_BEEF, 1);
    applyStimulus(1, 1, 2'b10, 2'b00, 0, 32'h0000_8000, 32'h5555_5555, 5'd12, 0, 0, 32'h0102_0304,
                  M_OK, 32'h0000_8000, 4'hF, 32'h0, 32'h0102_0304, 1);

    $display("[TB] stores with lane replication");
    applyStimulus(0, 1, 2'b00, 2'b00, 0, 32'h0000_3001, 32'h0000_00AB, 5'd0, 0, 0, 32'h0,
                  M_OK, 32'h0000_3000, 4'b0010, 32'hABAB_ABAB, 32'h0, 1);
    applyStimulus(0, 1, 2'b01, 2'b01, 0, 32'h0000_3002, 32'h1234_5678, 5'd0, 0, 0, 32'h0,
                  M_OK, 32'h0000_3000, 4'b1100, 32'h5678_5678, 32'h0, 1);
    applyStimulus(0, 1, 2'b10, 2'b10, 0, 32'h0000_7000, 32'hCAFE_F00D, 5'd0, 1, 0, 32'h0,
                  M_OK, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 32'h0, 1);

    $display("[TB] misaligned accesses");
    applyStimulus(1, 0, 2'b10, 2'b10, 0, 32'h0000_4002, 32'h0, 5'd4, 0, 0, 32'h0,
                  M_MIS, 32'h0, 4'h0, 32'h0, 32'h0, 1);
    applyStimulus(0, 1, 2'b01, 2'b01, 0, 32'h0000_4001, 32'hFFFF_FFFF, 5'd0, 0, 0, 32'h0,
                  M_MIS, 32'h0, 4'h0, 32'h0, 32'h0, 1);

    $display("[TB] response timeout and stray rvalid");
    applyStimulus(1, 0, 2'b10, 2'b10, 0, 32'h0000_5000, 32'h0, 5'd3, 0, -1, 32'h1111_2222,
                  M_TMO, 32'h0000_5000, 4'hF, 32'h0, 32'h0, 1);
    waitingResp = 1'b0;
    strayRvalid = 1'b1;
    s = cycle;
    pushItem(K_QUIET, s + 1, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0);
    pushItem(K_QUIET, s + 2, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0);
    @(posedge clk); #1;
    strayRvalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] back-to-back loads");
    applyStimulus(1, 0, 2'b00, 2'b00, 1, 32'h0000_1000, 32'h0, 5'd1, 0, 0, 32'h0000_007F,
                  M_OK, 32'h0000_1000, 4'hF, 32'h0, 32'h0000_007F, 0);
    repeat (2) begin @(posedge clk); #1; end
    applyStimulus(1, 0, 2'b01, 2'b01, 0, 32'h0000_1002, 32'h0, 5'd2, 0, 0, 32'h8000_1111,
                  M_OK, 32'h0000_1000, 4'hF, 32'h0, 32'h0000_8000, 1);

    $display("[TB] reset while waiting for load data");
    applyStimulus(1, 0, 2'b10, 2'b10, 0, 32'h0000_9000, 32'h0, 5'd6, 0, -1, 32'h0,
                  M_ABANDON, 32'h0000_9000, 4'hF, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    waitingResp = 1'b0;
    s = cycle;
    pushItem(K_ZERO, s + 1, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0);
    pushItem(K_QUIET, s + 2, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0);
    pushItem(K_QUIET, s + 5, 32'h0, 4'h0, 1'b0, 32'h0, 5'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    printSummary();
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected completion");
    printSummary();
    $finish;
  end

endmodule
